money_inner: RTL and testbench

- Coin-intake and credit controller for the vending machine; the upstream end of the change path.
- Accepts coin-insert strobes and accumulates credit. When credit reaches the item price, or on a cancel request, it issues the amount to return on `money`.
- Hands that amount to the downstream change dispenser and waits for its `flag` completion before taking new coins.

---
 rtl/money_inner.sv | 184 ++++++++++++++++++
 tb/tb_money_inner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/money_inner.sv
// money_inner: coin-intake and credit controller, upstream end of the change path.
// Accumulates coin credit, pulses vend once the price is reached, and hands any
// change or refund to the downstream dispenser on money/money_vld until it
// acknowledges with flag.
// Optional build macro MONEY_INNER_SYNC_EN: treat coin_a/b/c and cancel as raw
// asynchronous levels, synchronised and edge-detected before use.
module money_inner #(
    parameter logic [7:0] PRICE      = 8'd100,
    parameter logic [7:0] MAX_CREDIT = 8'd250,
    parameter logic [7:0] COIN_A     = 8'd5,
    parameter logic [7:0] COIN_B     = 8'd10,
    parameter logic [7:0] COIN_C     = 8'd25
) (
    input  logic       sclk,
    input  logic       srst_n,
    input  logic       coin_a,
    input  logic       coin_b,
    input  logic       coin_c,
    input  logic       cancel,
    input  logic       flag,
    output logic [7:0] money,
    output logic       money_vld,
    output logic       vend,
    output logic       coin_reject,
    output logic [7:0] credit,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_PAYOUT  = 2'd3;

    logic       coin_a_s, coin_b_s, coin_c_s, cancel_s;

`ifdef MONEY_INNER_SYNC_EN
    logic [3:0] sync1_r, sync2_r, sync3_r, pulse_r;

    // Two-flop synchroniser, then a registered rising-edge detector so a held level counts once.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            sync3_r <= 4'b0000;
            pulse_r <= 4'b0000;
        end else begin
            sync1_r <= {cancel, coin_c, coin_b, coin_a};
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            pulse_r <= sync2_r & ~sync3_r;
        end
    end

    assign {cancel_s, coin_c_s, coin_b_s, coin_a_s} = pulse_r;
`else
    assign coin_a_s = coin_a;
    assign coin_b_s = coin_b;
    assign coin_c_s = coin_c;
    assign cancel_s = cancel;
`endif

    logic [1:0] state_r, state_nxt_s;
    logic [7:0] credit_r, credit_nxt_s;
    logic [7:0] money_r, money_nxt_s;
    logic       money_vld_r, money_vld_nxt_s;
    logic       vend_r, vend_nxt_s;
    logic       reject_r, reject_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       coin_hit_s;
    logic [7:0] coin_val_s;
    logic [8:0] sum_s;
    logic       fits_s;

    // Pick the highest-priority coin (C > B > A) and form the 9-bit candidate credit.
    always_comb begin
        coin_hit_s = coin_a_s | coin_b_s | coin_c_s;
        if (coin_c_s) begin
            coin_val_s = COIN_C;
        end else if (coin_b_s) begin
            coin_val_s = COIN_B;
        end else if (coin_a_s) begin
            coin_val_s = COIN_A;
        end else begin
            coin_val_s = 8'd0;
        end
        sum_s  = {1'b0, credit_r} + {1'b0, coin_val_s};
        fits_s = (sum_s <= {1'b0, MAX_CREDIT});
    end

    // Next-state and next-output decode for the credit controller.
    always_comb begin
        state_nxt_s     = state_r;
        credit_nxt_s    = credit_r;
        money_nxt_s     = money_r;
        money_vld_nxt_s = money_vld_r;
        vend_nxt_s      = 1'b0;
        reject_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (cancel_s && (state_r == ST_COLLECT)) begin
                    // Refund: the whole credit moves into money; a same-cycle coin is refused.
                    state_nxt_s     = ST_PAYOUT;
                    money_nxt_s     = credit_r;
                    money_vld_nxt_s = 1'b1;
                    credit_nxt_s    = 8'd0;
                    reject_nxt_s    = coin_hit_s;
                end else if (coin_hit_s) begin
                    if (fits_s) begin
                        credit_nxt_s = sum_s[7:0];
                        if (sum_s >= {1'b0, PRICE}) begin
                            state_nxt_s = ST_VEND;
                        end else begin
                            state_nxt_s = ST_COLLECT;
                        end
                    end else begin
                        reject_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_VEND: begin
                vend_nxt_s   = 1'b1;
                reject_nxt_s = coin_hit_s;
                credit_nxt_s = 8'd0;
                if (credit_r > PRICE) begin
                    money_nxt_s     = credit_r - PRICE;
                    money_vld_nxt_s = 1'b1;
                    state_nxt_s     = ST_PAYOUT;
                end else begin
                    money_nxt_s     = 8'd0;
                    money_vld_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_PAYOUT: begin
                reject_nxt_s = coin_hit_s;
                if (flag) begin
                    money_nxt_s     = 8'd0;
                    money_vld_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAYOUT;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                credit_nxt_s    = 8'd0;
                money_nxt_s     = 8'd0;
                money_vld_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_VEND) || (state_nxt_s == ST_PAYOUT);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_r     <= ST_IDLE;
            credit_r    <= 8'd0;
            money_r     <= 8'd0;
            money_vld_r <= 1'b0;
            vend_r      <= 1'b0;
            reject_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            credit_r    <= credit_nxt_s;
            money_r     <= money_nxt_s;
            money_vld_r <= money_vld_nxt_s;
            vend_r      <= vend_nxt_s;
            reject_r    <= reject_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign money       = money_r;
    assign money_vld   = money_vld_r;
    assign vend        = vend_r;
    assign coin_reject = reject_r;
    assign credit      = credit_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_money_inner.sv
// Testbench for money_inner: vector table, hand-written corner sequences,
// and randomized traffic against a behavioural credit/payout model.
module tb_money_inner;

    logic       sclk = 1'b0;
    logic       srst_n;
    logic       coin_a, coin_b, coin_c, cancel, flag;
    logic [7:0] money, credit, s_money, s_credit;
    logic       money_vld, vend, coin_reject, busy;
    logic       s_money_vld, s_vend, s_coin_reject, s_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 sclk = ~sclk;

    money_inner dut (
        .sclk(sclk), .srst_n(srst_n), .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
        .cancel(cancel), .flag(flag), .money(money), .money_vld(money_vld), .vend(vend),
        .coin_reject(coin_reject), .credit(credit), .busy(busy)
    );

    money_inner #(.PRICE(8'd255)) dut_sat (
        .sclk(sclk), .srst_n(srst_n), .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
        .cancel(cancel), .flag(flag), .money(s_money), .money_vld(s_money_vld), .vend(s_vend),
        .coin_reject(s_coin_reject), .credit(s_credit), .busy(s_busy)
    );

    typedef struct packed {
        logic       a, b, c, cn, fl;
        logic [7:0] cr;
        logic [7:0] mo;
        logic       vld, vd, rj, bz;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mkv(input logic a, b, c, cn, fl, input logic [7:0] cr, mo,
                                 input logic vld, vd, rj, bz);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.cn = cn; v.fl = fl;
        v.cr = cr; v.mo = mo; v.vld = vld; v.vd = vd; v.rj = rj; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cr, input int mo, input int vld,
                           input int vd, input int rj, input int bz);
        chk({tag, ".credit"}, 32'(credit), 32'(cr));
        chk({tag, ".money"}, 32'(money), 32'(mo));
        chk({tag, ".money_vld"}, 32'(money_vld), 32'(vld));
        chk({tag, ".vend"}, 32'(vend), 32'(vd));
        chk({tag, ".coin_reject"}, 32'(coin_reject), 32'(rj));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic a, b, c, cn, fl);
        coin_a = a; coin_b = b; coin_c = c; cancel = cn; flag = fl;
        @(posedge sclk);
        #1;
        coin_a = 1'b0; coin_b = 1'b0; coin_c = 1'b0; cancel = 1'b0; flag = 1'b0;
    endtask

    task automatic do_reset();
        coin_a = 1'b0; coin_b = 1'b0; coin_c = 1'b0; cancel = 1'b0; flag = 1'b0;
        srst_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        srst_n = 1'b1;
    endtask

    // Behavioural model: plain-integer credit ledger plus payout obligation.
    int  m_credit, m_money;
    bit  m_paying, m_vend_due;
    int  e_vend, e_rej;

    task automatic model_step(input logic a, b, c, cn, fl);
        int value;
        bit any_coin;
        any_coin = a | b | c;
        value = c ? 25 : (b ? 10 : (a ? 5 : 0));
        e_vend = 0;
        e_rej  = 0;
        if (m_vend_due) begin
            e_vend     = 1;
            m_money    = m_credit - 100;
            m_credit   = 0;
            m_paying   = (m_money != 0);
            m_vend_due = 1'b0;
            e_rej      = any_coin;
        end else if (m_paying) begin
            e_rej = any_coin;
            if (fl) begin
                m_paying = 1'b0;
                m_money  = 0;
            end
        end else if (cn && m_credit != 0) begin
            m_money  = m_credit;
            m_credit = 0;
            m_paying = 1'b1;
            e_rej    = any_coin;
        end else if (any_coin) begin
            if (m_credit + value <= 250) begin
                m_credit = m_credit + value;
                if (m_credit >= 100) m_vend_due = 1'b1;
            end else begin
                e_rej = 1;
            end
        end
    endtask

    initial begin
        // Table: exact price, overpay with dropped coin, cancel/refund, idle-ignored strobes.
        tbl[0]  = mkv(0,0,1,0,0,  25, 0,0,0,0,0);
        tbl[1]  = mkv(0,0,1,0,0,  50, 0,0,0,0,0);
        tbl[2]  = mkv(0,0,1,0,0,  75, 0,0,0,0,0);
        tbl[3]  = mkv(0,0,1,0,0, 100, 0,0,0,0,1);
        tbl[4]  = mkv(0,0,0,0,0,   0, 0,0,1,0,0);
        tbl[5]  = mkv(0,0,0,0,0,   0, 0,0,0,0,0);
        tbl[6]  = mkv(0,0,1,0,0,  25, 0,0,0,0,0);
        tbl[7]  = mkv(0,0,1,0,0,  50, 0,0,0,0,0);
        tbl[8]  = mkv(0,0,1,0,0,  75, 0,0,0,0,0);
        tbl[9]  = mkv(0,1,1,0,0, 100, 0,0,0,0,1);
        tbl[10] = mkv(0,0,0,0,0,   0, 0,0,1,0,0);
        tbl[11] = mkv(1,0,0,0,0,   5, 0,0,0,0,0);
        tbl[12] = mkv(1,0,0,0,0,  10, 0,0,0,0,0);
        tbl[13] = mkv(1,0,0,0,0,  15, 0,0,0,0,0);
        tbl[14] = mkv(0,0,0,1,0,   0,15,1,0,0,1);
        tbl[15] = mkv(0,0,1,0,0,   0,15,1,0,1,1);
        tbl[16] = mkv(0,0,0,0,1,   0, 0,0,0,0,0);
        tbl[17] = mkv(0,0,0,1,0,   0, 0,0,0,0,0);
        tbl[18] = mkv(0,0,0,0,1,   0, 0,0,0,0,0);
        tbl[19] = mkv(0,1,0,0,0,  10, 0,0,0,0,0);
        tbl[20] = mkv(0,0,1,1,0,   0,10,1,0,1,1);
        tbl[21] = mkv(0,0,0,0,1,   0, 0,0,0,0,0);

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].cn, tbl[i].fl);
            chk_all($sformatf("tbl%0d", i), tbl[i].cr, tbl[i].mo, tbl[i].vld,
                    tbl[i].vd, tbl[i].rj, tbl[i].bz);
        end

        // Change: 9 x coin_b, coin_c -> 115; coin during VEND is rejected; money held until flag.
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
        chk("chg.credit90", 32'(credit), 32'd90);
        step(0, 0, 1, 0, 0);
        chk_all("chg.vendstate", 115, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk_all("chg.vend", 0, 15, 1, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            chk_all($sformatf("chg.hold%0d", i), 0, 15, 1, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1);
        chk_all("chg.flag", 0, 0, 0, 0, 0, 0);

        // Reset mid-PAYOUT clears outputs without any clock edge.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk_all("rst.payout", 0, 25, 1, 0, 0, 1);
        #1;
        srst_n = 1'b0;
        #1;
        chk_all("rst.async", 0, 0, 0, 0, 0, 0);
        @(negedge sclk);
        srst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk_all("rst.after", 0, 0, 0, 0, 0, 0);

        // Saturation on the PRICE=255 instance: credit stops at 250.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        chk("sat.credit", 32'(s_credit), 32'd250);
        chk("sat.noreject", 32'(s_coin_reject), 32'd0);
        step(1, 0, 0, 0, 0);
        chk("sat.reject", 32'(s_coin_reject), 32'd1);
        chk("sat.hold", 32'(s_credit), 32'd250);
        step(0, 0, 0, 0, 0);
        chk("sat.rejpulse", 32'(s_coin_reject), 32'd0);
        chk("sat.busy", 32'(s_busy), 32'd0);

        // Randomized traffic against the behavioural model.
        do_reset();
        m_credit = 0; m_money = 0; m_paying = 1'b0; m_vend_due = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic ra, rb, rc, rcn, rfl;
            ra  = ($urandom_range(0, 3) == 0);
            rb  = ($urandom_range(0, 3) == 0);
            rc  = ($urandom_range(0, 4) == 0);
            rcn = ($urandom_range(0, 15) == 0);
            rfl = ($urandom_range(0, 7) == 0);
            step(ra, rb, rc, rcn, rfl);
            model_step(ra, rb, rc, rcn, rfl);
            chk_all($sformatf("rnd%0d", i), m_credit, m_money, int'(m_paying), e_vend, e_rej,
                    int'(m_paying | m_vend_due));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
